// File: rtl/a2_limit_store_pkg.sv
// Shared ADPCM predictor definitions: a2 limits, coefficient/channel types, store FSM states.
package adpcm_pkg;

    localparam logic [15:0] A2UL = 16'h3000;
    localparam logic [15:0] A2LL = 16'hD000;

    localparam int CH_W_DEF = 5;

    typedef logic [15:0]          coef_t;
    typedef logic [CH_W_DEF-1:0]  ch_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/a2_limit_store_limc.sv
// LIMC clamp: limits a two's-complement coefficient to [A2LL, A2UL] with signed compares.
module limc
    import adpcm_pkg::*;
(
    input  coef_t a2t,
    output coef_t a2p
);

    always_comb begin
        a2p = a2t;
        if ($signed(a2t) > $signed(A2UL)) begin
            a2p = A2UL;
        end else if ($signed(a2t) < $signed(A2LL)) begin
            a2p = A2LL;
        end
    end

endmodule

// File: rtl/a2_limit_store.sv
// Per-channel a2 limit (LIMC) + transition reset (TRIGB) stage with a cleared-on-reset coefficient store.
// Optional clamp-event counter enabled by defining A2_SAT_CNT_EN.
module a2_limit_store
    import adpcm_pkg::*;
#(
    parameter int CHANNELS = 32,
    parameter int CH_W     = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_in0,
    input  logic            scan_in1,
    input  logic            scan_in2,
    input  logic            scan_in3,
    input  logic            scan_in4,
    input  logic            scan_enable,
    input  logic            test_mode,
    output logic            scan_out0,
    output logic            scan_out1,
    output logic            scan_out2,
    output logic            scan_out3,
    output logic            scan_out4,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_ch,
    input  logic [15:0]     a2t,
    input  logic            tr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH_W-1:0] out_ch,
    output logic [15:0]     a2p,
    output logic [15:0]     a2r,
    input  logic            rd_en,
    input  logic [CH_W-1:0] rd_ch,
    output logic [15:0]     rd_a2,
    output logic [15:0]     sat_cnt
);

    localparam logic [CH_W:0]   NUM_CH   = (CH_W+1)'(CHANNELS);
    localparam logic [CH_W-1:0] LAST_PTR = CH_W'(CHANNELS - 1);

    state_t          state;
    state_t          state_next;
    logic [CH_W-1:0] ptr;

    coef_t           a2p_c;
    coef_t           a2r_c;
    logic            in_range;
    logic            rd_in_range;
    logic            accept;

    logic            wr_en;
    logic [CH_W-1:0] wr_ch;
    coef_t           wr_data;

    coef_t           mem [CHANNELS];

    assign scan_out0 = test_mode & scan_enable & scan_in0;
    assign scan_out1 = test_mode & scan_enable & scan_in1;
    assign scan_out2 = test_mode & scan_enable & scan_in2;
    assign scan_out3 = test_mode & scan_enable & scan_in3;
    assign scan_out4 = test_mode & scan_enable & scan_in4;

    limc u_limc (
        .a2t (a2t),
        .a2p (a2p_c)
    );

    assign a2r_c       = tr ? '0 : a2p_c;
    assign in_range    = ({1'b0, in_ch} < NUM_CH);
    assign rd_in_range = ({1'b0, rd_ch} < NUM_CH);

    // Handshake: an update transfers on a rising edge where in_valid && in_ready;
    // a result transfers where out_valid && out_ready. in_ready never depends on in_valid.
    assign in_ready = (state == ST_RUN) && !reset && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // INIT sweeps zeros through the store; RUN commits accepted a2r values.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_ch      = ptr;
        wr_data    = '0;
        case (state)
            ST_INIT: begin
                wr_en = 1'b1;
                if (ptr == LAST_PTR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_en   = accept && in_range;
                wr_ch   = in_ch;
                wr_data = a2r_c;
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ch] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            a2p       <= '0;
            a2r       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            a2p       <= a2p_c;
            a2r       <= a2r_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Write-first: a same-cycle write to the read channel forwards the new value.
    always_ff @(posedge clk) begin
        if (reset || state == ST_INIT) begin
            rd_a2 <= '0;
        end else if (rd_en) begin
            if (wr_en && wr_ch == rd_ch) begin
                rd_a2 <= wr_data;
            end else if (rd_in_range) begin
                rd_a2 <= mem[rd_ch];
            end else begin
                rd_a2 <= '0;
            end
        end
    end

`ifdef A2_SAT_CNT_EN
    logic sat_event;
    assign sat_event = accept && (a2p_c != a2t);

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_cnt <= '0;
        end else if (sat_event && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`else
    assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_a2_limit_store.sv
// Directed bench for a2_limit_store: INIT sweep, LIMC/TRIGB values, back-pressure, write-first reads, reset.
module tb_a2_limit_store;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic        scan_enable, test_mode;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
    logic        in_valid, in_ready;
    logic [4:0]  in_ch;
    logic [15:0] a2t;
    logic        tr;
    logic        out_valid, out_ready;
    logic [4:0]  out_ch;
    logic [15:0] a2p, a2r;
    logic        rd_en;
    logic [4:0]  rd_ch;
    logic [15:0] rd_a2;
    logic [15:0] sat_cnt;

    int total = 0;
    int bad   = 0;
    int exp_sat = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    a2_limit_store dut (
        .clk         (clk),
        .reset       (reset),
        .scan_in0    (scan_in0),
        .scan_in1    (scan_in1),
        .scan_in2    (scan_in2),
        .scan_in3    (scan_in3),
        .scan_in4    (scan_in4),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ch       (in_ch),
        .a2t         (a2t),
        .tr          (tr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .a2p         (a2p),
        .a2r         (a2r),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .rd_a2       (rd_a2),
        .sat_cnt     (sat_cnt)
    );

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one update and hold it until accepted (bounded); returns with in_valid low.
    task automatic upd(input logic [4:0] ch, input logic [15:0] v, input logic t, output bit ok);
        int n;
        #1;
        in_valid = 1'b1;
        in_ch    = ch;
        a2t      = v;
        tr       = t;
        n        = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        ok = (in_ready === 1'b1);
        step();
        in_valid = 1'b0;
        tr       = 1'b0;
    endtask

    task automatic note_sat(input bit outside);
`ifdef A2_SAT_CNT_EN
        if (outside) exp_sat++;
`else
        if (outside) exp_sat = exp_sat;
`endif
    endtask

    task automatic test_reset();
        bit early_ready;
        bit init_rd_nz;
        reset = 1'b1;
        in_valid = 1'b0; in_ch = '0; a2t = '0; tr = 1'b0;
        out_ready = 1'b1; rd_en = 1'b0; rd_ch = '0;
        scan_enable = 1'b1; test_mode = 1'b0;
        {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'b11111;
        step();
        step();
        total++;
        if ({in_ready, out_valid, out_ch, a2p, a2r, rd_a2, sat_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_values: got rdy=%b ov=%b ch=%0d a2p=%h a2r=%h rd=%h sat=%h, need all 0",
                     in_ready, out_valid, out_ch, a2p, a2r, rd_a2, sat_cnt);
        end
        total++;
        if ({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} !== 5'b00000) begin
            bad++;
            $display("FAIL scan_functional: got %b, need 00000",
                     {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4});
        end
        scan_enable = 1'b0;
        reset = 1'b0;
        rd_en = 1'b1;
        early_ready = 1'b0;
        init_rd_nz = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            rd_ch = 5'(k);
            step();
            if (in_ready !== 1'b0) early_ready = 1'b1;
            if (rd_a2 !== 16'h0000) init_rd_nz = 1'b1;
        end
        total++;
        if (early_ready !== 1'b0) begin
            bad++;
            $display("FAIL init_ready_low: in_ready rose before cycle 33, need low for 32 cycles");
        end
        total++;
        if (init_rd_nz !== 1'b0) begin
            bad++;
            $display("FAIL init_read_zero: rd_a2 nonzero during INIT, need 0");
        end
        step();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL init_ready_rise: in_ready=%b after 32 cycles, need 1", in_ready);
        end
        for (int c = 0; c < 32; c++) begin
            rd_ch = 5'(c);
            step();
            total++;
            if (rd_a2 !== 16'h0000) begin
                bad++;
                $display("FAIL cleared_read ch%0d: got %h, need 0000", c, rd_a2);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_clamp();
        bit ok;
        logic [15:0] tv_a2t [8] = '{16'hC000, 16'h1234, 16'h3000, 16'hD000,
                                    16'h3001, 16'hCFFF, 16'h7FFF, 16'h8000};
        logic [15:0] tv_exp [8] = '{16'hD000, 16'h1234, 16'h3000, 16'hD000,
                                    16'h3000, 16'hD000, 16'h3000, 16'hD000};
        bit          tv_out [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        upd(5'd3, 16'h4000, 1'b0, ok);
        note_sat(1'b1);
        total++;
        if (!ok || out_valid !== 1'b1 || out_ch !== 5'd3 || a2p !== 16'h3000 || a2r !== 16'h3000) begin
            bad++;
            $display("FAIL clamp_high: ok=%b ov=%b ch=%0d a2p=%h a2r=%h, need 1 1 3 3000 3000",
                     ok, out_valid, out_ch, a2p, a2r);
        end
        rd_en = 1'b1; rd_ch = 5'd3;
        step();
        rd_en = 1'b0;
        total++;
        if (rd_a2 !== 16'h3000) begin
            bad++;
            $display("FAIL store_ch3: got %h, need 3000", rd_a2);
        end
        total++;
        if (sat_cnt !== 16'(exp_sat)) begin
            bad++;
            $display("FAIL sat_after_ch3: got %0d, need %0d", sat_cnt, exp_sat);
        end
        for (int i = 0; i < 8; i++) begin
            upd(5'd7, tv_a2t[i], 1'b0, ok);
            note_sat(tv_out[i]);
            total++;
            if (!ok || a2p !== tv_exp[i] || a2r !== tv_exp[i] || out_ch !== 5'd7) begin
                bad++;
                $display("FAIL limc_vec%0d a2t=%h: ok=%b a2p=%h a2r=%h ch=%0d, need %h %h ch7",
                         i, tv_a2t[i], ok, a2p, a2r, out_ch, tv_exp[i], tv_exp[i]);
            end
            step();
            total++;
            if (sat_cnt !== 16'(exp_sat)) begin
                bad++;
                $display("FAIL sat_vec%0d: got %0d, need %0d", i, sat_cnt, exp_sat);
            end
        end
    endtask

    task automatic test_trigb();
        bit ok;
        upd(5'd5, 16'h0200, 1'b0, ok);
        upd(5'd5, 16'h0100, 1'b1, ok);
        total++;
        if (!ok || a2p !== 16'h0100 || a2r !== 16'h0000) begin
            bad++;
            $display("FAIL trigb_out: ok=%b a2p=%h a2r=%h, need 0100 0000", ok, a2p, a2r);
        end
        rd_en = 1'b1; rd_ch = 5'd5;
        step();
        rd_en = 1'b0;
        total++;
        if (rd_a2 !== 16'h0000) begin
            bad++;
            $display("FAIL trigb_store: got %h, need 0000", rd_a2);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        upd(5'd1, 16'h0011, 1'b0, ok);
        in_valid = 1'b1; in_ch = 5'd2; a2t = 16'h0022; tr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_ready%0d: got %b, need 0", i, in_ready);
            end
            step();
            total++;
            if (out_valid !== 1'b1 || a2p !== 16'h0011 || out_ch !== 5'd1) begin
                bad++;
                $display("FAIL bp_hold%0d: ov=%b a2p=%h ch=%0d, need 1 0011 1", i, out_valid, a2p, out_ch);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got %b, need 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || a2p !== 16'h0022 || out_ch !== 5'd2) begin
            bad++;
            $display("FAIL bp_release: ov=%b a2p=%h ch=%0d, need 1 0022 2", out_valid, a2p, out_ch);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_single_accept: out_valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [5] = '{16'h0005, 16'h5000, 16'hF000, 16'hA000, 16'h2FFF};
        logic [15:0] lims [5] = '{16'h0005, 16'h3000, 16'hF000, 16'hD000, 16'h2FFF};
        bit          outs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_ch = 5'(10 + i); a2t = vals[i]; tr = 1'b0;
            exp_q.push_back(lims[i]);
            note_sat(outs[i]);
            step();
            e = exp_q.pop_front();
            total++;
            if (out_valid !== 1'b1 || a2p !== e || out_ch !== 5'(10 + i)) begin
                bad++;
                $display("FAIL b2b%0d: ov=%b a2p=%h ch=%0d, need 1 %h %0d", i, out_valid, a2p, out_ch, e, 10 + i);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || sat_cnt !== 16'(exp_sat)) begin
            bad++;
            $display("FAIL b2b_end: ov=%b sat=%0d, need 0 %0d", out_valid, sat_cnt, exp_sat);
        end
    endtask

    task automatic test_write_read();
        bit ok;
        upd(5'd9, 16'h0111, 1'b0, ok);
        in_valid = 1'b1; in_ch = 5'd9; a2t = 16'h0ABC; tr = 1'b0;
        rd_en = 1'b1; rd_ch = 5'd9;
        step();
        in_valid = 1'b0; rd_en = 1'b0;
        total++;
        if (rd_a2 !== 16'h0ABC) begin
            bad++;
            $display("FAIL write_first: got %h, need 0ABC", rd_a2);
        end
        upd(5'd9, 16'h0123, 1'b0, ok);
        total++;
        if (rd_a2 !== 16'h0ABC) begin
            bad++;
            $display("FAIL rd_hold: got %h, need 0ABC", rd_a2);
        end
        rd_en = 1'b1; rd_ch = 5'd9;
        step();
        rd_en = 1'b0;
        total++;
        if (rd_a2 !== 16'h0123) begin
            bad++;
            $display("FAIL rd_after_write: got %h, need 0123", rd_a2);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        logic [4:0] chans [6] = '{5'd3, 5'd4, 5'd5, 5'd7, 5'd9, 5'd12};
        out_ready = 1'b0;
        upd(5'd4, 16'h0444, 1'b0, ok);
        reset = 1'b1;
        step();
        exp_sat = 0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || a2p !== 16'h0000 || sat_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset: ov=%b rdy=%b a2p=%h sat=%h, need 0 0 0000 0000",
                     out_valid, in_ready, a2p, sat_cnt);
        end
        reset = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        total++;
        if (n !== 32) begin
            bad++;
            $display("FAIL mid_reset_init_len: ready after %0d cycles, need 32", n);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_ch = chans[i];
            step();
            total++;
            if (rd_a2 !== 16'h0000) begin
                bad++;
                $display("FAIL recleared ch%0d: got %h, need 0000", chans[i], rd_a2);
            end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clamp();
        test_trigb();
        test_backpressure();
        test_back_to_back();
        test_write_read();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
